// File: rtl/sdp_fifo_if.sv
// sdp_fifo_if: producer/consumer stream bundle for the first-word-fall-through FIFO
interface sdp_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count
    );
endinterface

// File: rtl/sdp_fifo.sv
// sdp_fifo: FWFT FIFO wrapping a registered-read simple dual-port RAM; head word lives in the RAM rdata register
module simple_dual_port_ram_reg1 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  wclock,
    input  logic                  wenable,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rclock,
    input  logic                  renable,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge wclock)
        if (wenable) mem[waddr] <= wdata;

    always_ff @(posedge rclock)
        if (renable) rdata <= mem[raddr];
endmodule

module sdp_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic       clock,
    input logic       resetn,
    sdp_fifo_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [ADDR_WIDTH:0]   ram_count;
    logic                  out_valid;
    logic                  push, pop, fetch;

    assign bus.in_ready  = ram_count != FULL;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = out_valid & bus.out_ready;
    // refill the head register whenever it is empty or being consumed
    assign fetch         = (ram_count != '0) & (~out_valid | bus.out_ready);
    assign bus.out_valid = out_valid;
    assign bus.count     = ram_count + (ADDR_WIDTH+1)'(out_valid);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_count <= '0;
            out_valid <= 1'b0;
        end else begin
            wptr      <= wptr + ADDR_WIDTH'(push);
            rptr      <= rptr + ADDR_WIDTH'(fetch);
            ram_count <= ram_count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(fetch);
            out_valid <= fetch | (out_valid & ~pop);
        end
    end

    simple_dual_port_ram_reg1 #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .wclock (clock),
        .wenable(push),
        .waddr  (wptr),
        .wdata  (bus.in_data),
        .rclock (clock),
        .renable(fetch),
        .raddr  (rptr),
        .rdata  (bus.out_data)
    );
endmodule

// File: tb/tb_sdp_fifo.sv
// tb_sdp_fifo: directed and scoreboarded checks of the FWFT FIFO
module tb_sdp_fifo;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [7:0] q[$];

    sdp_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sdp_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // inputs are already set; model the coming edge, advance, then check
    task automatic tick();
        logic       stall;
        logic [7:0] d;
        stall = resetn && bus.out_valid && !bus.out_ready;
        d = bus.out_data;
        if (!resetn) q.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("pop_empty", 32'd1, 32'd0);
                else check("order", 32'(bus.out_data), 32'(q.pop_front()));
            end
            if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
        end
        @(posedge clock);
        #1;
        if (stall) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", 32'(bus.out_data), 32'(d));
        end
        check("count", 32'(bus.count), 32'(q.size()));
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && bus.count != 0; i++) tick();
        check("drain_done", 32'(bus.count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        bus.out_ready = 1'b0;
        #1;
        repeat (3) tick();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        resetn = 1'b1;
        bus.in_valid = 1'b0;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        tick();

        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("single_lat_valid", 32'(bus.out_valid), 32'd0);
        check("single_count", 32'(bus.count), 32'd1);
        tick();
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_data", 32'(bus.out_data), 32'hA5);
        tick();
        check("single_pop_valid", 32'(bus.out_valid), 32'd0);
        check("single_pop_count", 32'(bus.count), 32'd0);

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.in_data = 8'(i);
            tick();
        end
        check("fill_count", 32'(bus.count), 32'd17);
        check("fill_ready", 32'(bus.in_ready), 32'd0);
        check("fill_head", 32'(bus.out_data), 32'd0);
        bus.in_data = 8'h11;
        tick();
        check("full_ignore", 32'(bus.count), 32'd17);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check("drain_valid", 32'(bus.out_valid), 32'd1);
            check("drain_data", 32'(bus.out_data), 32'(i));
            tick();
            if (i == 0) check("unfull_ready", 32'(bus.in_ready), 32'd1);
        end
        check("drain_empty", 32'(bus.out_valid), 32'd0);

        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_data = 8'(i);
            tick();
            if (i >= 1) check("stream_valid", 32'(bus.out_valid), 32'd1);
            check("stream_cnt", 32'(bus.count <= 2), 32'd1);
        end
        drain();

        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        drain();

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.in_data = 8'(8'h40 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("mid_count", 32'(bus.count), 32'd9);
        resetn = 1'b0;
        tick();
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        resetn = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h3C;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5 && !bus.out_valid; i++) tick();
        check("mid_valid", 32'(bus.out_valid), 32'd1);
        check("mid_first", 32'(bus.out_data), 32'h3C);
        bus.out_ready = 1'b1;
        tick();
        check("mid_empty", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
